// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FWFT FIFO with frame-error tag, sticky overrun and level/idle interrupt
// Optional idle-timeout interrupt is built when UART_RX_FIFO_TIMEOUT_EN is defined.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  input  logic                  wr_frame_error,
  input  logic                  rd_en,
  input  logic                  clear_overrun,
  input  logic [DEPTH_LOG2:0]   thresh,
  input  logic [15:0]           timeout,
  output logic [DATA_WIDTH:0]   rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overrun,
  output logic                  irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = DEPTH[DEPTH_LOG2:0];

  logic [DATA_WIDTH:0]   mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  overrun_q, overrun_d;
  logic                  push_acc, pop_acc;
  logic                  lvl_irq;

  assign empty   = (level_q == '0);
  assign full    = (level_q == FULL_LVL);
  assign level   = level_q;
  assign overrun = overrun_q;
  assign rd_data = mem_q[rptr_q];

  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign pop_acc  = rd_en && !empty;
  assign push_acc = wr_valid && (!full || pop_acc);

  // Storage write; contents need no reset because level gates visibility.
  always_ff @(posedge clk) begin
    if (push_acc && !flush) begin
      mem_q[wptr_q] <= {wr_frame_error, wr_data};
    end
  end

  // Next-state for pointers, level and the sticky overrun flag; flush dominates.
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    level_d   = level_q;
    overrun_d = overrun_q;
    if (flush) begin
      wptr_d    = '0;
      rptr_d    = '0;
      level_d   = '0;
      overrun_d = 1'b0;
    end else begin
      if (push_acc) wptr_d = wptr_q + 1'b1;
      if (pop_acc)  rptr_d = rptr_q + 1'b1;
      if (push_acc && !pop_acc)      level_d = level_q + 1'b1;
      else if (pop_acc && !push_acc) level_d = level_q - 1'b1;
      if (wr_valid && !push_acc)     overrun_d = 1'b1;
      else if (clear_overrun)        overrun_d = 1'b0;
    end
  end

  // State registers for pointers, level and overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
    end
  end

  assign lvl_irq = (thresh != '0) && (level_q >= thresh);

`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic [15:0] idle_q, idle_d;
  logic        tflag_q, tflag_d;

  // Idle counter restarts on any traffic or while empty and saturates at timeout.
  always_comb begin
    idle_d  = idle_q;
    tflag_d = tflag_q;
    if (flush) begin
      idle_d  = '0;
      tflag_d = 1'b0;
    end else begin
      if (push_acc || pop_acc || empty) idle_d = '0;
      else if (idle_q < timeout)        idle_d = idle_q + 16'd1;
      if (push_acc || pop_acc)                      tflag_d = 1'b0;
      else if ((timeout != '0) && (idle_q >= timeout)) tflag_d = 1'b1;
    end
  end

  // Idle counter and sticky timeout flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q  <= '0;
      tflag_q <= 1'b0;
    end else begin
      idle_q  <= idle_d;
      tflag_q <= tflag_d;
    end
  end

  assign irq = lvl_irq | tflag_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout;
  assign irq = lvl_irq;
`endif

endmodule
